video_fill_engine: RTL and testbench
====================================

Name: video_fill_engine

Overview:
- Rectangle-fill engine upstream of the video unit. It drives the video unit's memory port (mem_clk side) and writes a constant 32-bit colour into a W x H block of video memory.
- Host CPU accesses pass through the same port and take strict priority over the engine.
- The framebuffer is word-addressed with a 128-word row pitch (pixel word = {y[7:1], x[7:1]} + base), so stride is programmable per command.

Parameters:
- ADDR_WIDTH, 15, video-memory word address width (mem_addr is ADDR_WIDTH+1 bits; MSB=1 selects control registers).
- DIM_WIDTH, 8, width of the rectangle width/height fields.
- DATA_WIDTH, 32, memory data width.

Ports:
- clk_a  in  1  Memory-side clock; the same clock as video unit mem_clk.
- rst  in  1  Reset, asynchronous, active-high.
- cmd_valid  in  1  Fill command valid.
- cmd_ready  out  1  Engine can accept a command.
- cmd_base  in  15  Word address of the top-left word.
- cmd_stride  in  15  Word distance between rows (nominally 128).
- cmd_width  in  8  Words per row.
- cmd_height  in  8  Row count.
- cmd_color  in  32  Fill value.
- busy  out  1  Command in progress.
- done  out  1  One-cycle pulse when a command completes.
- host_en  in  1  Host access strobe.
- host_we  in  4  Host byte write enables.
- host_addr  in  16  Host address (bit 15 = control register space).
- host_write  in  32  Host write data.
- host_read  out  32  Host read data.
- mem_en  out  1  To video unit mem_en.
- mem_we  out  4  To video unit mem_we.
- mem_addr  out  16  To video unit mem_addr.
- mem_write  out  32  To video unit mem_write.
- mem_read  in  32  From video unit mem_read.

Behaviour:
- Reset is clk_a domain only; rst is asynchronous, active-high.
  - Reset forces state=IDLE; col, row, row_addr and the latched command fields = 0.
  - cmd_ready=1, busy=0, done=0.
  - Engine-side mem drive is 0. mem_* still carry host signals combinationally.
- States and transitions:
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch base/stride/width/height/color, clear col/row, set row_addr=base.
    - If width==0 or height==0, go to DONE (no writes issued).
    - Otherwise go to FILL.
  - FILL: cmd_ready=0, busy=1. Each cycle with host_en=0, issue one write: mem_en=1, mem_we=4'hF, mem_addr={1'b0, (row_addr+col) mod 2^15}, mem_write=color.
    - If col==width-1: col<=0, row<=row+1, row_addr<=row_addr+stride (mod 2^15).
    - Else: col<=col+1.
    - On the write with col==width-1 and row==height-1, go to DONE.
  - DONE: busy=0, cmd_ready=0, done=1 for exactly this cycle; next state IDLE.
- Port mux, combinational:
  - If host_en=1, mem_* = host_* unconditionally and the engine stalls; col, row and state hold.
  - Otherwise mem_* = engine drive, or all zero when not in FILL.
  - host_read = mem_read: pass-through with the video unit's 1-cycle read latency, no added latency.
- Engine writes always have mem_addr[15]=0; the engine never touches control registers.
- Address arithmetic is 15-bit modulo; a rectangle crossing 0x7FFF wraps to 0x0000.
- Latency with no host contention, command accepted at cycle 0:
  - Writes occur on cycles 1..W*H, row-major.
  - done is high on cycle W*H+1.
  - cmd_ready returns on cycle W*H+2.
- Back-to-back commands: a command presented while busy is held off (cmd_ready=0). cmd_* are sampled only at acceptance; later changes are ignored.
- Host access in the same cycle as the engine's final write: host wins, and the final write is issued on the next free cycle.
- Reset mid-FILL aborts immediately. No done pulse; partially written memory is left as is.
- width=1: each write advances row. height=1: a single row.

Test Plan:
- base=0x0100, stride=128, W=3, H=2, color=0x00FF0000 -> writes to 0x100, 0x101, 0x102, 0x180, 0x181, 0x182 with we=F on cycles 1-6; done on cycle 7; cmd_ready high again on cycle 8.
- W=4, H=1, host_en pulsed on cycles 2 and 3 -> those cycles show host addr/data on mem_*; engine writes at 0,1,2,3 on cycles 1,4,5,6; done on cycle 7.
- W=0, H=5 -> no mem_en from the engine; done on cycle 1; busy never asserted.
- base=0x7FFE, W=4, H=1 -> addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001; mem_addr[15] always 0.
- W=8, H=8, rst asserted asynchronously after the 10th write -> mem_en=0 immediately; state IDLE with cmd_ready=1 after release; no done pulse; a new 1x1 command then completes normally.
- Host read of 0x8000 during IDLE -> mem_addr=0x8000, mem_en=1, mem_we=0; host_read equals mem_read one cycle later (cr_base value).

Source files
------------

// File: rtl/video_fill_engine.sv
// Rectangle-fill engine sharing the video unit's memory port with the host CPU.
// Writes a constant colour into a W x H block; host accesses always win the port.
module video_fill_engine #(
    parameter int ADDR_WIDTH = 15,
    parameter int DIM_WIDTH  = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_a,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_base,
    input  logic [ADDR_WIDTH-1:0]   cmd_stride,
    input  logic [DIM_WIDTH-1:0]    cmd_width,
    input  logic [DIM_WIDTH-1:0]    cmd_height,
    input  logic [DATA_WIDTH-1:0]   cmd_color,
    output logic                    busy,
    output logic                    done,
    input  logic                    host_en,
    input  logic [DATA_WIDTH/8-1:0] host_we,
    input  logic [ADDR_WIDTH:0]     host_addr,
    input  logic [DATA_WIDTH-1:0]   host_write,
    output logic [DATA_WIDTH-1:0]   host_read,
    output logic                    mem_en,
    output logic [DATA_WIDTH/8-1:0] mem_we,
    output logic [ADDR_WIDTH:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_write,
    input  logic [DATA_WIDTH-1:0]   mem_read
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    state_t                  state, state_next;
    logic [DIM_WIDTH-1:0]    col, row;
    logic [ADDR_WIDTH-1:0]   row_addr;
    logic [ADDR_WIDTH-1:0]   lat_stride;
    logic [DIM_WIDTH-1:0]    lat_width, lat_height;
    logic [DATA_WIDTH-1:0]   lat_color;
    logic [ADDR_WIDTH-1:0]   engine_addr;
    logic                    accept, advance, last_col, last_row;

    assign accept      = (state == IDLE) && cmd_valid;
    // A host access steals the port for the whole cycle, so the engine only
    // advances on cycles the host leaves free.
    assign advance     = (state == FILL) && !host_en;
    assign last_col    = (col == lat_width - DIM_WIDTH'(1));
    assign last_row    = (row == lat_height - DIM_WIDTH'(1));
    assign engine_addr = row_addr + ADDR_WIDTH'(col);

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == FILL);
    assign done      = (state == DONE);
    assign host_read = mem_read;

    always_comb begin
        // NOTE: every output of a combinational block is given a default first,
        // so no path leaves it unassigned and no latch is inferred.
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_width == '0 || cmd_height == '0)
                        state_next = DONE;
                    else
                        state_next = FILL;
                end
            end
            FILL: begin
                if (advance && last_col && last_row)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_a or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            row_addr   <= '0;
            lat_stride <= '0;
            lat_width  <= '0;
            lat_height <= '0;
            lat_color  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                lat_stride <= cmd_stride;
                lat_width  <= cmd_width;
                lat_height <= cmd_height;
                lat_color  <= cmd_color;
                col        <= '0;
                row        <= '0;
                row_addr   <= cmd_base;
            end else if (advance) begin
                if (last_col) begin
                    col      <= '0;
                    row      <= row + DIM_WIDTH'(1);
                    row_addr <= row_addr + lat_stride;
                end else begin
                    col <= col + DIM_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_write = '0;
        if (host_en) begin
            mem_en    = 1'b1;
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_write = host_write;
        end else if (state == FILL) begin
            // Engine writes are confined to the frame buffer half of the map.
            mem_en    = 1'b1;
            mem_we    = '1;
            mem_addr  = {1'b0, engine_addr};
            mem_write = lat_color;
        end
    end

endmodule

// File: tb/tb_video_fill_engine.sv
// Directed bench for video_fill_engine: per-cycle vector tables for fill
// commands plus hand-written sequences for host read and reset mid-fill.
module tb_video_fill_engine;

    localparam logic [31:0] CR_BASE_VAL = 32'h0000_1234;

    logic        clk_a = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [14:0] cmd_base, cmd_stride;
    logic [7:0]  cmd_width, cmd_height;
    logic [31:0] cmd_color;
    logic        busy, done;
    logic        host_en;
    logic [3:0]  host_we;
    logic [15:0] host_addr;
    logic [31:0] host_write, host_read;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write, mem_read;

    video_fill_engine dut (
        .clk_a(clk_a), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base(cmd_base), .cmd_stride(cmd_stride),
        .cmd_width(cmd_width), .cmd_height(cmd_height), .cmd_color(cmd_color),
        .busy(busy), .done(done),
        .host_en(host_en), .host_we(host_we), .host_addr(host_addr),
        .host_write(host_write), .host_read(host_read),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_write(mem_write), .mem_read(mem_read)
    );

    always #5 clk_a = ~clk_a;

    // Video unit read port: one-cycle latency, control space returns cr_base.
    always @(posedge clk_a) begin
        if (mem_en && mem_we == 4'h0)
            mem_read <= mem_addr[15] ? CR_BASE_VAL : {16'hBEEF, mem_addr};
    end

    typedef struct {
        logic        cv;
        logic        he;
        logic [3:0]  hw;
        logic [15:0] ha;
        logic [31:0] hd;
        logic [20:0] exp_bus;   // {mem_en, mem_we, mem_addr}
        logic [31:0] exp_data;
        logic [2:0]  exp_flags; // {cmd_ready, busy, done}
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic cv, input logic he, input logic [3:0] hw,
                                input logic [15:0] ha, input logic [31:0] hd,
                                input logic [20:0] eb, input logic [31:0] ed,
                                input logic [2:0] ef);
        vec_t v;
        v.cv = cv; v.he = he; v.hw = hw; v.ha = ha; v.hd = hd;
        v.exp_bus = eb; v.exp_data = ed; v.exp_flags = ef;
        vecs.push_back(v);
    endfunction

    function automatic void v_quiet(input logic cv, input logic [2:0] flags);
        add(cv, 1'b0, 4'h0, 16'h0, 32'h0, 21'h0, 32'h0, flags);
    endfunction

    function automatic void v_eng(input logic cv, input logic [14:0] a, input logic [31:0] c);
        add(cv, 1'b0, 4'h0, 16'h0, 32'h0, {1'b1, 4'hF, 1'b0, a}, c, 3'b010);
    endfunction

    function automatic void v_host(input logic cv, input logic [3:0] we, input logic [15:0] a,
                                   input logic [31:0] d, input logic [2:0] flags);
        add(cv, 1'b1, we, a, d, {1'b1, we, a}, d, flags);
    endfunction

    task automatic start_cmd(input logic [14:0] base, input logic [14:0] stride,
                             input logic [7:0] w, input logic [7:0] h, input logic [31:0] c);
        cmd_base = base; cmd_stride = stride; cmd_width = w; cmd_height = h; cmd_color = c;
    endtask

    // Vector 0 is the acceptance cycle; afterwards the command fields are
    // scrambled to prove they are only sampled at acceptance.
    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            cmd_valid  = vecs[i].cv;
            host_en    = vecs[i].he;
            host_we    = vecs[i].hw;
            host_addr  = vecs[i].ha;
            host_write = vecs[i].hd;
            if (i > 0) start_cmd(15'h1357, 15'h0003, 8'd2, 8'd2, 32'hBAD0_BAD0);
            #1;
            check($sformatf("%s[%0d] bus", tag, i), 64'({mem_en, mem_we, mem_addr}), 64'(vecs[i].exp_bus));
            check($sformatf("%s[%0d] data", tag, i), 64'(mem_write), 64'(vecs[i].exp_data));
            check($sformatf("%s[%0d] flags", tag, i), 64'({cmd_ready, busy, done}), 64'(vecs[i].exp_flags));
            @(posedge clk_a);
            #1;
        end
        cmd_valid = 1'b0;
        host_en   = 1'b0;
        host_we   = 4'h0;
        host_addr = 16'h0;
        vecs.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; host_en = 1'b0; host_we = 4'h0; host_addr = 16'h0; host_write = 32'h0;
        start_cmd(15'h0, 15'h0, 8'h0, 8'h0, 32'h0);
        #12;
        check("reset flags", 64'({cmd_ready, busy, done}), 64'(3'b100));
        check("reset bus", 64'({mem_en, mem_we, mem_addr}), 64'(21'h0));
        @(negedge clk_a) rst = 1'b0;
        @(posedge clk_a);
        #1;

        // 3x2 rectangle, pitch 128
        start_cmd(15'h0100, 15'd128, 8'd3, 8'd2, 32'h00FF_0000);
        v_quiet(1'b1, 3'b100);
        v_eng(1'b1, 15'h0100, 32'h00FF_0000);
        v_eng(1'b1, 15'h0101, 32'h00FF_0000);
        v_eng(1'b1, 15'h0102, 32'h00FF_0000);
        v_eng(1'b1, 15'h0180, 32'h00FF_0000);
        v_eng(1'b1, 15'h0181, 32'h00FF_0000);
        v_eng(1'b1, 15'h0182, 32'h00FF_0000);
        v_quiet(1'b1, 3'b001);
        v_quiet(1'b0, 3'b100);
        run_vecs("rect3x2");

        // 4x1 with host cycles 2 and 3 stealing the port
        start_cmd(15'h0200, 15'd128, 8'd4, 8'd1, 32'h1234_5678);
        v_quiet(1'b1, 3'b100);
        v_eng(1'b1, 15'h0200, 32'h1234_5678);
        v_host(1'b1, 4'h3, 16'h8004, 32'hCAFE_F00D, 3'b010);
        v_host(1'b1, 4'h3, 16'h0010, 32'h1111_2222, 3'b010);
        v_eng(1'b1, 15'h0201, 32'h1234_5678);
        v_eng(1'b1, 15'h0202, 32'h1234_5678);
        v_eng(1'b1, 15'h0203, 32'h1234_5678);
        v_quiet(1'b1, 3'b001);
        v_quiet(1'b0, 3'b100);
        run_vecs("host_steal");

        // zero width: straight to done, no writes, never busy
        start_cmd(15'h0300, 15'd128, 8'd0, 8'd5, 32'hFFFF_FFFF);
        v_quiet(1'b1, 3'b100);
        v_quiet(1'b1, 3'b001);
        v_quiet(1'b0, 3'b100);
        run_vecs("zero_w");

        // wrap across 0x7FFF
        start_cmd(15'h7FFE, 15'd128, 8'd4, 8'd1, 32'hA5A5_A5A5);
        v_quiet(1'b1, 3'b100);
        v_eng(1'b1, 15'h7FFE, 32'hA5A5_A5A5);
        v_eng(1'b1, 15'h7FFF, 32'hA5A5_A5A5);
        v_eng(1'b1, 15'h0000, 32'hA5A5_A5A5);
        v_eng(1'b1, 15'h0001, 32'hA5A5_A5A5);
        v_quiet(1'b1, 3'b001);
        v_quiet(1'b0, 3'b100);
        run_vecs("wrap");

        // width 1, stride 16, host collides with the final write
        start_cmd(15'h0050, 15'h0010, 8'd1, 8'd2, 32'h0F0F_0F0F);
        v_quiet(1'b1, 3'b100);
        v_eng(1'b1, 15'h0050, 32'h0F0F_0F0F);
        v_host(1'b1, 4'h0, 16'h8001, 32'h0, 3'b010);
        v_eng(1'b1, 15'h0060, 32'h0F0F_0F0F);
        v_quiet(1'b1, 3'b001);
        v_quiet(1'b0, 3'b100);
        run_vecs("last_collide");

        // host read of control space while idle
        host_en = 1'b1; host_we = 4'h0; host_addr = 16'h8000; host_write = 32'h0;
        #1;
        check("hread bus", 64'({mem_en, mem_we, mem_addr}), 64'({1'b1, 4'h0, 16'h8000}));
        check("hread flags", 64'({cmd_ready, busy, done}), 64'(3'b100));
        @(posedge clk_a);
        #1;
        host_en = 1'b0; host_addr = 16'h0;
        #1;
        check("hread data", 64'(host_read), 64'(CR_BASE_VAL));
        @(posedge clk_a);
        #1;

        // 8x8 fill aborted by reset after the 10th write
        start_cmd(15'h0000, 15'd128, 8'd8, 8'd8, 32'h0000_0001);
        cmd_valid = 1'b1;
        #1;
        check("abort accept", 64'(cmd_ready), 64'(1'b1));
        @(posedge clk_a);
        #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("abort write%0d", i), 64'({mem_en, mem_we, mem_addr}),
                  64'({1'b1, 4'hF, 16'((i / 8) * 128 + (i % 8))}));
            @(posedge clk_a);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        check("abort bus", 64'({mem_en, mem_we, mem_addr}), 64'(21'h0));
        check("abort flags", 64'({cmd_ready, busy, done}), 64'(3'b100));
        @(negedge clk_a) rst = 1'b0;
        @(posedge clk_a);
        #1;
        check("post-abort flags", 64'({cmd_ready, busy, done}), 64'(3'b100));

        start_cmd(15'h0ABC, 15'd128, 8'd1, 8'd1, 32'h0000_0077);
        v_quiet(1'b1, 3'b100);
        v_eng(1'b1, 15'h0ABC, 32'h0000_0077);
        v_quiet(1'b0, 3'b001);
        v_quiet(1'b0, 3'b100);
        run_vecs("after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
